// File: rtl/ddr_arb_pkg.sv
// Shared types and defaults for the two-port DDR request arbiter.
package ddr_arb_pkg;

  localparam int unsigned NPORT      = 2;
  localparam int unsigned DEF_ADDR_W = 30;
  localparam int unsigned DEF_DATA_W = 256;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_RESP = 2'd2
  } arb_state_e;

endpackage

// File: rtl/rr_pick2.sv
// Combinational 2-way round-robin picker; on a tie the port that was not served last wins.
module rr_pick2
  import ddr_arb_pkg::*;
(
  input  logic [NPORT-1:0] req,
  input  logic             last,
  output logic [NPORT-1:0] gnt
);

  always_comb begin
    gnt = '0;
    unique case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = last ? 2'b01 : 2'b10;
      default: gnt = '0;
    endcase
  end

endmodule

// File: rtl/ddr_arbiter.sv
// Round-robin arbiter sharing one ddr_ctrl request port between I-cache (port 0) and
// D-cache (port 1); latches the winner's request and returns data with a one-cycle rdy pulse.
module ddr_arbiter
  import ddr_arb_pkg::*;
#(
  parameter int unsigned ADDR_W  = DEF_ADDR_W,
  parameter int unsigned DATA_W  = DEF_DATA_W,
  parameter int unsigned TIMEOUT = 4096
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              p0_en,
  input  logic              p0_write,
  input  logic [ADDR_W-1:0] p0_addr,
  input  logic [DATA_W-1:0] p0_wdata,
  output logic              p0_rdy,
  output logic [DATA_W-1:0] p0_rdata,
  input  logic              p1_en,
  input  logic              p1_write,
  input  logic [ADDR_W-1:0] p1_addr,
  input  logic [DATA_W-1:0] p1_wdata,
  output logic              p1_rdy,
  output logic [DATA_W-1:0] p1_rdata,
  output logic              ram_en,
  output logic              ram_write,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] data_to_ram,
  input  logic              ram_rdy,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic [1:0]        grant,
  output logic [1:0]        arb_state,
  output logic              timeout_err
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT) + 1;

  arb_state_e       state;
  logic             last_served;
  logic [CNT_W-1:0] busy_cnt;
  logic [1:0]       pick;

  assign arb_state = state;

  rr_pick2 u_pick (
    .req  ({p1_en, p0_en}),
    .last (last_served),
    .gnt  (pick)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= S_IDLE;
      last_served <= 1'b1;
      busy_cnt    <= '0;
      ram_en      <= 1'b0;
      ram_write   <= 1'b0;
      ram_addr    <= '0;
      data_to_ram <= '0;
      grant       <= '0;
      p0_rdy      <= 1'b0;
      p1_rdy      <= 1'b0;
      p0_rdata    <= '0;
      p1_rdata    <= '0;
      timeout_err <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (|pick) begin
            ram_en   <= 1'b1;
            grant    <= pick;
            busy_cnt <= '0;
            state    <= S_BUSY;
            if (pick[1]) begin
              ram_write   <= p1_write;
              ram_addr    <= p1_addr;
              data_to_ram <= p1_wdata;
            end else begin
              ram_write   <= p0_write;
              ram_addr    <= p0_addr;
              data_to_ram <= p0_wdata;
            end
          end
        end
        S_BUSY: begin
          if (ram_rdy) begin
            ram_en      <= 1'b0;
            last_served <= grant[1];
            state       <= S_RESP;
            if (grant[1]) begin
              p1_rdy <= 1'b1;
              if (!ram_write) p1_rdata <= ram_rdata;
            end else begin
              p0_rdy <= 1'b1;
              if (!ram_write) p0_rdata <= ram_rdata;
            end
          end else begin
            // Saturate so a very long stall cannot wrap the counter.
            if (busy_cnt != CNT_W'(TIMEOUT)) busy_cnt <= busy_cnt + 1'b1;
            if (busy_cnt == CNT_W'(TIMEOUT - 1)) timeout_err <= 1'b1;
          end
        end
        S_RESP: begin
          p0_rdy <= 1'b0;
          p1_rdy <= 1'b0;
          grant  <= '0;
          state  <= S_IDLE;
        end
        default: begin
          ram_en <= 1'b0;
          p0_rdy <= 1'b0;
          p1_rdy <= 1'b0;
          grant  <= '0;
          state  <= S_IDLE;
        end
      endcase
    end
  end

endmodule
